// File: rtl/core_launch_scheduler_if.sv
// Control/status bundle between the HPS control block, the compute cores and
// the launch scheduler.
interface core_launch_scheduler_if #(
    parameter int CORE_NUM = 4
);
    logic                start;
    logic [CORE_NUM-1:0] core_en;
    logic [CORE_NUM-1:0] core_done;
    logic [CORE_NUM-1:0] core_start;
    logic                busy;
    logic                finish;
    logic                timeout_err;
    logic [CORE_NUM-1:0] done_mask;

    modport master (
        output start, core_en, core_done,
        input  core_start, busy, finish, timeout_err, done_mask
    );

    modport slave (
        input  start, core_en, core_done,
        output core_start, busy, finish, timeout_err, done_mask
    );
endinterface

// File: rtl/core_launch_scheduler.sv
// Launch sequencer: staggers start pulses to the enabled cores, collects their
// done pulses and emits one finish pulse per launch, aborting on timeout.
module core_launch_scheduler #(
    parameter int CORE_NUM = 4,
    parameter int TMO_W    = 16,
    parameter int TMO_CYC  = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    core_launch_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

    state_t              state_reg, state_next;
    logic                start_q_reg;
    logic [CORE_NUM-1:0] act_mask_reg, act_mask_next;
    logic [CORE_NUM-1:0] pend_reg, pend_next;
    logic [CORE_NUM-1:0] done_mask_reg, done_mask_next;
    logic [CORE_NUM-1:0] core_start_reg, core_start_next;
    logic [TMO_W-1:0]    tmo_reg, tmo_next;
    logic                busy_reg, busy_next;
    logic                finish_reg, finish_next;
    logic                tmo_err_reg, tmo_err_next;

    logic                accept;
    logic                all_done;
    logic                tmo_hit;
    logic [CORE_NUM-1:0] pend_low;
    logic [CORE_NUM-1:0] pend_rest;

    // pend_reg holds the enabled cores not yet started; the lowest one goes next.
    genvar gi;
    generate
        for (gi = 0; gi < CORE_NUM; gi++) begin : g_pick
            if (gi == 0) begin : g_first
                assign pend_low[gi] = pend_reg[gi];
            end else begin : g_rest
                assign pend_low[gi] = pend_reg[gi] & ~(|pend_reg[gi-1:0]);
            end
        end
    endgenerate

    assign pend_rest = pend_reg & ~pend_low;
    assign accept    = bus.start & ~start_q_reg & (state_reg == IDLE);
    assign all_done  = ((done_mask_reg & act_mask_reg) == act_mask_reg);
    assign tmo_hit   = (tmo_reg == TMO_W'(TMO_CYC - 1));

    always_comb begin
        state_next      = state_reg;
        act_mask_next   = act_mask_reg;
        pend_next       = pend_reg;
        done_mask_next  = done_mask_reg;
        core_start_next = '0;
        tmo_next        = tmo_reg;
        busy_next       = busy_reg;
        finish_next     = 1'b0;
        tmo_err_next    = tmo_err_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    act_mask_next  = bus.core_en;
                    pend_next      = bus.core_en;
                    done_mask_next = '0;
                    tmo_err_next   = 1'b0;
                    tmo_next       = '0;
                    busy_next      = 1'b1;
                    if (bus.core_en == '0) begin
                        state_next  = FINISH;
                        finish_next = 1'b1;
                    end else begin
                        state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                done_mask_next = done_mask_reg | (bus.core_done & act_mask_reg);
                tmo_next       = tmo_reg + TMO_W'(1);
                if (tmo_hit && !all_done) begin
                    // Abort drops any cores still waiting for their start pulse.
                    tmo_err_next = 1'b1;
                    pend_next    = '0;
                    state_next   = FINISH;
                    finish_next  = 1'b1;
                end else begin
                    core_start_next = pend_low;
                    pend_next       = pend_rest;
                    if (pend_rest == '0) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                done_mask_next = done_mask_reg | (bus.core_done & act_mask_reg);
                tmo_next       = tmo_reg + TMO_W'(1);
                if (all_done) begin
                    state_next  = FINISH;
                    finish_next = 1'b1;
                end else if (tmo_hit) begin
                    tmo_err_next = 1'b1;
                    state_next   = FINISH;
                    finish_next  = 1'b1;
                end
            end
            FINISH: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            start_q_reg    <= 1'b0;
            act_mask_reg   <= '0;
            pend_reg       <= '0;
            done_mask_reg  <= '0;
            core_start_reg <= '0;
            tmo_reg        <= '0;
            busy_reg       <= 1'b0;
            finish_reg     <= 1'b0;
            tmo_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_q_reg    <= bus.start;
            act_mask_reg   <= act_mask_next;
            pend_reg       <= pend_next;
            done_mask_reg  <= done_mask_next;
            core_start_reg <= core_start_next;
            tmo_reg        <= tmo_next;
            busy_reg       <= busy_next;
            finish_reg     <= finish_next;
            tmo_err_reg    <= tmo_err_next;
        end
    end

    assign bus.core_start  = core_start_reg;
    assign bus.busy        = busy_reg;
    assign bus.finish      = finish_reg;
    assign bus.timeout_err = tmo_err_reg;
    assign bus.done_mask   = done_mask_reg;
endmodule
